arbiter_vc: RTL
===============

ARBITER_VC -- requirements
Module: arbiter_vc

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive VC0 grants while VC1 is non-empty.
REQ-002 Parameter CNT_WIDTH, default 5, SHALL set the width of the per-VC grant counters.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 VC0_empty  input  1  VC0 FIFO holds no word.
REQ-006 VC1_empty  input  1  VC1 FIFO holds no word.
REQ-007 D0_almost_full  input  1  downstream D0 FIFO near capacity.
REQ-008 D1_almost_full  input  1  downstream D1 FIFO near capacity.
REQ-009 pop_VC0  output  1  combinational read strobe to the VC0 FIFO.
REQ-010 pop_VC1  output  1  combinational read strobe to the VC1 FIFO.
REQ-011 pop_delay_VC0  output  1  pop_VC0 registered one cycle; enables the VC0 mux path.
REQ-012 pop_delay_VC1  output  1  pop_VC1 registered one cycle; enables the VC1 mux path.
REQ-013 cnt_VC0  output  CNT_WIDTH  running count of VC0 grants.
REQ-014 cnt_VC1  output  CNT_WIDTH  running count of VC1 grants.
REQ-015 state  output  2  current FSM state, for debug.

Function
REQ-016 States SHALL be IDLE (2'b00), ACTIVE (2'b01), PAUSE (2'b10); 2'b11 SHALL decode as IDLE.
REQ-017 stall = D0_almost_full | D1_almost_full; any state with stall=1 SHALL go to PAUSE next cycle.
REQ-018 IDLE -> ACTIVE when stall=0 and either VC non-empty; otherwise remain.
REQ-019 ACTIVE -> IDLE when both VCs empty and stall=0.
REQ-020 PAUSE -> ACTIVE when stall=0 and either VC non-empty, PAUSE -> IDLE when stall=0 and both empty.
REQ-021 Pops SHALL be issued only in ACTIVE with stall=0 in the same cycle; never in IDLE or PAUSE.
REQ-022 pop_VC0 and pop_VC1 SHALL be mutually exclusive; at most one grant per cycle.
REQ-023 Strict priority: VC0 granted whenever non-empty, except under REQ-024.
REQ-024 Starvation guard: after STARVE_LIMIT consecutive VC0 grants with VC1 non-empty, the next grant SHALL go to VC1 if VC1 is non-empty.
REQ-025 Consecutive-VC0 counter SHALL clear on any VC1 grant or when VC1 is empty, and hold while no grant occurs.
REQ-026 A pop SHALL never be asserted for an empty VC.
REQ-027 pop_delay_VCx SHALL equal pop_VCx of the previous cycle exactly, giving one-cycle latency aligned with registered FIFO read data.
REQ-028 cnt_VCx SHALL increment by 1 per grant, modulo 2^CNT_WIDTH (31 -> 0 at default).
REQ-029 Stall rising mid-stream: the pop in the stall cycle SHALL be suppressed; the pop_delay for the previous cycle's pop SHALL still be asserted.

Reset
REQ-030 While reset=1, state SHALL be IDLE, all pop and pop_delay outputs 0, counters and the starvation counter 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL immediately drop pop_delay outputs; no pop SHALL be issued in the first edge after reset release.

Structure
REQ-032 State encodings and the STARVE_LIMIT default SHALL live in shared package vc_arb_pkg.
REQ-033 The starvation counter SHALL be sub-module arb_starve_cnt (inputs: grant_VC0, grant_VC1, VC1_empty; output: force_VC1).
REQ-034 Outputs SHALL be driven so that arbiter_vc connects directly to the VC mux pop_delay inputs.

Verification
REQ-035 Reset pulse mid-traffic -> all outputs 0 asynchronously; state=IDLE; counters 0.
REQ-036 VC0 and VC1 both non-empty, no stall, 10 cycles -> grant pattern VC0 x4, VC1 x1, VC0 x4, VC1 x1; cnt_VC0=8, cnt_VC1=2.
REQ-037 VC1 only non-empty for 3 cycles -> pop_VC1 on 3 consecutive cycles, pop_delay_VC1 on the same 3 cycles shifted +1.
REQ-038 D1_almost_full raised for 2 cycles during ACTIVE -> PAUSE, no pops for those cycles, pending pop_delay still issued, ACTIVE resumes when stall clears.
REQ-039 33 VC0 grants from reset -> cnt_VC0 wraps to 1.
REQ-040 Both VCs empty -> IDLE, pops 0; VC0 goes non-empty -> ACTIVE next edge, pop_VC0 asserted in that ACTIVE cycle.

Source files
------------

// File: rtl/vc_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_arb_pkg
//  Purpose  : Shared state encodings and defaults for the VC arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package vc_arb_pkg;

    localparam int C_STARVE_LIMIT_DEFAULT = 4;
    localparam int C_CNT_WIDTH_DEFAULT    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_PAUSE  = 2'b10
    } arb_state_e;

    // Width able to hold 0..limit; never zero so the counter always exists.
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_vc_if.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_vc_if
//  Purpose  : FIFO status / pop strobe bundle between arbiter and VC FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
interface arbiter_vc_if #(
    parameter int CNT_WIDTH = vc_arb_pkg::C_CNT_WIDTH_DEFAULT
);
    logic                 VC0_empty;
    logic                 VC1_empty;
    logic                 D0_almost_full;
    logic                 D1_almost_full;
    logic                 pop_VC0;
    logic                 pop_VC1;
    logic                 pop_delay_VC0;
    logic                 pop_delay_VC1;
    logic [CNT_WIDTH-1:0] cnt_VC0;
    logic [CNT_WIDTH-1:0] cnt_VC1;
    logic [1:0]           state;

    modport master (
        input  VC0_empty, VC1_empty, D0_almost_full, D1_almost_full,
        output pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1,
               cnt_VC0, cnt_VC1, state
    );

    modport slave (
        output VC0_empty, VC1_empty, D0_almost_full, D1_almost_full,
        input  pop_VC0, pop_VC1, pop_delay_VC0, pop_delay_VC1,
               cnt_VC0, cnt_VC1, state
    );
endinterface
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_cnt
//  Purpose  : Counts consecutive VC0 grants while VC1 waits; forces a VC1 turn.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_starve_cnt
    import vc_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = C_STARVE_LIMIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic grant_VC0,
    input  wire logic grant_VC1,
    input  wire logic VC1_empty,
    output logic      force_VC1
);
    localparam int              SCW     = starve_cnt_width(STARVE_LIMIT);
    localparam logic [SCW-1:0]  C_LIMIT = SCW'(STARVE_LIMIT);

    logic [SCW-1:0] r_consec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_consec <= '0;
        end else if (grant_VC1 || VC1_empty) begin
            r_consec <= '0;
        end else if (grant_VC0 && (r_consec != C_LIMIT)) begin
            r_consec <= r_consec + SCW'(1);
        end
    end

    assign force_VC1 = ~VC1_empty & (r_consec >= C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/arbiter_vc.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_vc
//  Purpose  : Two-VC strict-priority pop arbiter with starvation guard and
//             downstream back-pressure pause.
//  Revision : 1.0 - initial release
// ============================================================================
module arbiter_vc
    import vc_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = C_STARVE_LIMIT_DEFAULT,
    parameter int CNT_WIDTH    = C_CNT_WIDTH_DEFAULT
) (
    input  wire logic    clk,
    input  wire logic    reset,
    arbiter_vc_if.master bus
);
    arb_state_e           r_state;
    logic                 r_pop_delay_vc0;
    logic                 r_pop_delay_vc1;
    logic [CNT_WIDTH-1:0] r_cnt_vc0;
    logic [CNT_WIDTH-1:0] r_cnt_vc1;

    logic w_stall;
    logic w_any;
    logic w_grant_ok;
    logic w_force_vc1;
    logic w_pop_vc0;
    logic w_pop_vc1;

    assign w_stall    = bus.D0_almost_full | bus.D1_almost_full;
    assign w_any      = ~bus.VC0_empty | ~bus.VC1_empty;
    assign w_grant_ok = (r_state == ST_ACTIVE) & ~w_stall;

    // VC0 wins unless the starvation guard hands this slot to VC1.
    assign w_pop_vc0 = w_grant_ok & ~bus.VC0_empty & ~w_force_vc1;
    assign w_pop_vc1 = w_grant_ok & ~bus.VC1_empty & ~w_pop_vc0;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .reset     (reset),
        .grant_VC0 (w_pop_vc0),
        .grant_VC1 (w_pop_vc1),
        .VC1_empty (bus.VC1_empty),
        .force_VC1 (w_force_vc1)
    );

    // Every state shares the same exits, so the next state depends only on inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_pop_delay_vc0 <= 1'b0;
            r_pop_delay_vc1 <= 1'b0;
            r_cnt_vc0       <= '0;
            r_cnt_vc1       <= '0;
        end else begin
            if (w_stall) begin
                r_state <= ST_PAUSE;
            end else if (w_any) begin
                r_state <= ST_ACTIVE;
            end else begin
                r_state <= ST_IDLE;
            end

            r_pop_delay_vc0 <= w_pop_vc0;
            r_pop_delay_vc1 <= w_pop_vc1;

            if (w_pop_vc0) begin
                r_cnt_vc0 <= r_cnt_vc0 + CNT_WIDTH'(1);
            end
            if (w_pop_vc1) begin
                r_cnt_vc1 <= r_cnt_vc1 + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pop_VC0       = w_pop_vc0;
    assign bus.pop_VC1       = w_pop_vc1;
    assign bus.pop_delay_VC0 = r_pop_delay_vc0;
    assign bus.pop_delay_VC1 = r_pop_delay_vc1;
    assign bus.cnt_VC0       = r_cnt_vc0;
    assign bus.cnt_VC1       = r_cnt_vc1;
    assign bus.state         = r_state;

endmodule
`default_nettype wire
